// File: rtl/mult_div_unit.sv
// Iterative signed multiply / restoring divide with HI/LO result registers.
// One operand bit per cycle in CALC, then one FIX cycle applies signs.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [3:0] OP_MULT = 4'b1111;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam int         CW      = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     bmag_q, bmag_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 bzero_q, bzero_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [WIDTH:0]       upper;
    logic [2*WIDTH:0]     shifted;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     amag;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        bmag_d    = bmag_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        upper     = '0;
        shifted   = '0;
        prod      = '0;
        amag      = a[WIDTH-1] ? -a : a;

        case (state_q)
            IDLE: begin
                if (start && (alu_ctrl == OP_MULT || alu_ctrl == OP_DIV)) begin
                    is_div_d  = (alu_ctrl == OP_DIV);
                    a_d       = a;
                    bmag_d    = b[WIDTH-1] ? -b : b;
                    acc_d     = {{(WIDTH+1){1'b0}}, amag};
                    neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
                    neg_rem_d = a[WIDTH-1];
                    bzero_d   = (b == '0);
                    count_d   = CW'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    shifted = acc_q << 1;
                    if (shifted[2*WIDTH:WIDTH] >= {1'b0, bmag_q})
                        acc_d = {shifted[2*WIDTH:WIDTH] - {1'b0, bmag_q},
                                 shifted[WIDTH-1:1], 1'b1};
                    else
                        acc_d = shifted;
                end else begin
                    upper = acc_q[0] ? acc_q[2*WIDTH:WIDTH] + {1'b0, bmag_q}
                                     : acc_q[2*WIDTH:WIDTH];
                    acc_d = {1'b0, upper, acc_q[WIDTH-1:1]};
                end
                count_d = count_q - 1'b1;
                if (count_d == '0)
                    state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    if (bzero_q) begin
                        hi_d  = a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        // Remainder follows the dividend's sign; quotient the xor.
                        hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                        lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    end
                end else begin
                    prod = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            bmag_q    <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            bmag_q    <= bmag_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule
